seg7_scan_mux: RTL

Time-multiplexed four-digit seven-segment scanner that sits directly downstream of the rotating-banner logic. It accepts a packed 4-digit hex word over a valid/ready handshake and double-buffers it. The new word becomes visible only at a frame boundary, so the display never shows a torn frame. Each cycle it drives one active-low anode with the decoded active-low segment pattern, and it supports per-digit blanking and 8-level brightness PWM.

---
 rtl/seg7_scan_mux.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit multiplexed seven-segment scanner.
// Accepts a packed 4-digit hex word over valid/ready, double-buffers it so a
// new word only becomes visible at a frame boundary, and scans one active-low
// anode at a time with per-digit blanking and 8-level brightness PWM.
module seg7_scan_mux #(
    parameter int PHASE_LEN = 6250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [3:0]  blank,
    input  logic [2:0]  bright,
    output logic [6:0]  segment,
    output logic [3:0]  anode,
    output logic        frame_tick
);

    // Prescaler width; a PHASE_LEN of 1 still needs a one-bit counter.
    localparam int              PRE_W    = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PHASE_LEN - 1);

    // Hex to seven-segment pattern, active-high, bit order gfedcba.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Scan counters.
    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_phase;
    logic [1:0]       r_slot;

    // Double buffer.
    logic [15:0]      r_active;
    logic [15:0]      r_shadow;
    logic             r_pending;

    // Registered pins.
    logic [6:0]       r_segment;
    logic [3:0]       r_anode;
    logic             r_frame_tick;

    // Decode of counter state.
    logic             w_pre_wrap;
    logic             w_phase_wrap;
    logic             w_boundary;
    logic             w_xfer;
    logic             w_lit;
    logic [3:0]       w_nibble;
    logic [3:0]       w_anode_next;
    logic [6:0]       w_segment_next;

    assign w_pre_wrap   = (r_pre == PRE_LAST);
    assign w_phase_wrap = (r_phase == 3'd7);
    assign w_boundary   = w_pre_wrap && w_phase_wrap && (r_slot == 2'd3);
    // The shadow only accepts a word while it is empty.
    assign w_xfer       = din_valid && !r_pending;

    // Advance the prescaler, phase and slot counters; all wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_phase <= 3'd0;
            r_slot  <= 2'd0;
        end else if (w_pre_wrap) begin
            r_pre   <= '0;
            r_phase <= r_phase + 3'd1;
            if (w_phase_wrap) begin
                r_slot <= r_slot + 2'd1;
            end else begin
                r_slot <= r_slot;
            end
        end else begin
            r_pre   <= r_pre + PRE_W'(1);
            r_phase <= r_phase;
            r_slot  <= r_slot;
        end
    end

    // Shadow capture and frame-boundary promotion; a word offered on the
    // boundary edge while the shadow is empty goes straight to active.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active  <= 16'h0000;
            r_shadow  <= 16'h0000;
            r_pending <= 1'b0;
        end else if (w_boundary) begin
            if (r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (din_valid) begin
                r_active  <= din;
            end else begin
                r_active  <= r_active;
            end
        end else if (w_xfer) begin
            r_shadow  <= din;
            r_pending <= 1'b1;
        end else begin
            r_shadow  <= r_shadow;
            r_pending <= r_pending;
        end
    end

    // Select the nibble for the current slot and form the next pin values.
    always_comb begin
        w_nibble       = 4'h0;
        w_anode_next   = 4'b1111;
        w_segment_next = 7'b1111111;
        w_lit          = (r_phase <= bright) && !blank[r_slot];
        case (r_slot)
            2'd0:    w_nibble = r_active[3:0];
            2'd1:    w_nibble = r_active[7:4];
            2'd2:    w_nibble = r_active[11:8];
            2'd3:    w_nibble = r_active[15:12];
            default: w_nibble = 4'h0;
        endcase
        if (w_lit) begin
            w_anode_next   = ~(4'b0001 << r_slot);
            w_segment_next = ~seg_decode(w_nibble);
        end else begin
            w_anode_next   = 4'b1111;
            w_segment_next = 7'b1111111;
        end
    end

    // Register the display pins and the frame pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_anode      <= 4'b1111;
            r_segment    <= 7'b1111111;
            r_frame_tick <= 1'b0;
        end else begin
            r_anode      <= w_anode_next;
            r_segment    <= w_segment_next;
            r_frame_tick <= w_boundary;
        end
    end

    assign din_ready  = !r_pending;
    assign anode      = r_anode;
    assign segment    = r_segment;
    assign frame_tick = r_frame_tick;

endmodule
